// File: rtl/capture_store_ctrl.sv
// Capture buffer controller: records a stream of words into an on-chip buffer
// in one-shot or ring mode, then returns PACK consecutive words per read beat.
// Optional feature macro: CAPTURE_STORE_TIMESTAMP_EN adds a free-running cycle
// counter and a start_ts output holding the counter value at the first stored
// word of each capture.
module capture_store_ctrl #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 2048,
   parameter int unsigned PACK   = 4,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic                     data_in_valid,
   input  logic [DATA_W-1:0]        data_in,
   input  logic                     cmd_record,
   input  logic                     cmd_mode,
   input  logic                     cmd_stop,
   input  logic                     cmd_read_request,
   input  logic [ADDR_W-1:0]        read_request_addr,
   output logic [DATA_W*PACK-1:0]   read_data_out,
   output logic                     read_data_valid,
   output logic                     done,
   output logic                     ready,
   output logic [ADDR_W:0]          wr_count,
   output logic                     wrap_flag
`ifdef CAPTURE_STORE_TIMESTAMP_EN
   ,
   output logic [31:0]              start_ts
`endif
);

   localparam int unsigned       CNT_W     = $clog2(PACK + 1);
   localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StRecord, StRead} state_e;

   state_e                   state_q, state_d;
   logic                     mode_q, mode_d;
   logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]          wr_count_q, wr_count_d;
   logic                     wrap_q, wrap_d;
   logic                     done_q, done_d;
   logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
   logic [CNT_W-1:0]         rd_cnt_q, rd_cnt_d;
   logic [DATA_W*PACK-1:0]   pack_q, pack_d;
   logic [DATA_W*PACK-1:0]   rdo_q, rdo_d;
   logic                     rdv_q, rdv_d;
   logic                     wr_en;

   logic [DATA_W-1:0]        mem [DEPTH];
   logic [DATA_W-1:0]        mem_q;

   assign wr_en = sys_rst_n && (state_q == StRecord) && data_in_valid;

   // Buffer storage: single write port, registered read (1-cycle latency).
   always_ff @(posedge sys_clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= data_in;
      end
      mem_q <= mem[rd_addr_q];
   end

   // Next-state logic for the capture/read FSM and its datapath.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      wr_ptr_d   = wr_ptr_q;
      wr_count_d = wr_count_q;
      wrap_d     = wrap_q;
      done_d     = done_q;
      rd_addr_d  = rd_addr_q;
      rd_cnt_d   = rd_cnt_q;
      pack_d     = pack_q;
      rdo_d      = rdo_q;
      rdv_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Record has priority; a simultaneous read request is dropped.
            if (cmd_record) begin
               state_d    = StRecord;
               mode_d     = cmd_mode;
               wr_ptr_d   = '0;
               wr_count_d = '0;
               wrap_d     = 1'b0;
               done_d     = 1'b0;
            end else if (cmd_read_request) begin
               state_d   = StRead;
               // Offsets are relative to the oldest word once the ring wrapped.
               rd_addr_d = (wrap_q ? wr_ptr_q : '0) + read_request_addr;
               rd_cnt_d  = '0;
            end
         end
         StRecord: begin
            if (wr_en) begin
               wr_ptr_d = wr_ptr_q + ADDR_W'(1);
               if (wr_count_q != FullCount) begin
                  wr_count_d = wr_count_q + (ADDR_W + 1)'(1);
               end
               if (wr_ptr_q == LastAddr) begin
                  if (mode_q) begin
                     wrap_d = 1'b1;
                  end else begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end
               end
            end
            if (cmd_stop) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         StRead: begin
            // Address k issued while rd_cnt == k; its word arrives at rd_cnt == k+1.
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            rd_cnt_d  = rd_cnt_q + CNT_W'(1);
            for (int k = 0; k < PACK; k++) begin
               if (rd_cnt_q == CNT_W'(k + 1)) begin
                  pack_d[k*DATA_W +: DATA_W] = mem_q;
               end
            end
            if (rd_cnt_q == CNT_W'(PACK)) begin
               state_d = StIdle;
               rdv_d   = 1'b1;
               rdo_d   = pack_d;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q    <= StIdle;
         mode_q     <= 1'b0;
         wr_ptr_q   <= '0;
         wr_count_q <= '0;
         wrap_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_addr_q  <= '0;
         rd_cnt_q   <= '0;
         pack_q     <= '0;
         rdo_q      <= '0;
         rdv_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         wr_ptr_q   <= wr_ptr_d;
         wr_count_q <= wr_count_d;
         wrap_q     <= wrap_d;
         done_q     <= done_d;
         rd_addr_q  <= rd_addr_d;
         rd_cnt_q   <= rd_cnt_d;
         pack_q     <= pack_d;
         rdo_q      <= rdo_d;
         rdv_q      <= rdv_d;
      end
   end

`ifdef CAPTURE_STORE_TIMESTAMP_EN
   logic [31:0] ts_q;
   logic [31:0] start_ts_q;
   logic        first_q;

   // Free-running cycle counter; latch it on the first stored word of a capture.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         ts_q       <= '0;
         start_ts_q <= '0;
         first_q    <= 1'b0;
      end else begin
         ts_q <= ts_q + 32'd1;
         if (state_q == StIdle && cmd_record) begin
            first_q <= 1'b1;
         end else if (wr_en && first_q) begin
            start_ts_q <= ts_q;
            first_q    <= 1'b0;
         end
      end
   end

   assign start_ts = start_ts_q;
`endif

   assign ready           = (state_q == StIdle);
   assign done            = done_q;
   assign wr_count        = wr_count_q;
   assign wrap_flag       = wrap_q;
   assign read_data_out   = rdo_q;
   assign read_data_valid = rdv_q;

endmodule

// File: tb/tb_capture_store_ctrl.sv
// Directed plus randomized bench for capture_store_ctrl (DEPTH=16, PACK=4).
// Expected buffer contents come from a word-level model: an array indexed by
// write position, with the logical read offset taken from the oldest word.
module tb_capture_store_ctrl;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int PACK  = 4;
   localparam int AW    = 4;
   localparam int BW    = DW * PACK;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n = 1'b0;
   logic          data_in_valid = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          cmd_record = 1'b0;
   logic          cmd_mode = 1'b0;
   logic          cmd_stop = 1'b0;
   logic          cmd_read_request = 1'b0;
   logic [AW-1:0] read_request_addr = '0;
   logic [BW-1:0] read_data_out;
   logic          read_data_valid;
   logic          done;
   logic          ready;
   logic [AW:0]   wr_count;
   logic          wrap_flag;

   int errors = 0;
   int checks = 0;

   // Word-level model of the buffer.
   logic [31:0] m_mem [DEPTH];
   int          m_ptr = 0;
   int          m_count = 0;
   bit          m_wrap = 1'b0;
   bit          m_ring = 1'b0;

   capture_store_ctrl #(
      .DATA_W (DW),
      .DEPTH  (DEPTH),
      .PACK   (PACK),
      .ADDR_W (AW)
   ) dut (
      .sys_clk           (sys_clk),
      .sys_rst_n         (sys_rst_n),
      .data_in_valid     (data_in_valid),
      .data_in           (data_in),
      .cmd_record        (cmd_record),
      .cmd_mode          (cmd_mode),
      .cmd_stop          (cmd_stop),
      .cmd_read_request  (cmd_read_request),
      .read_request_addr (read_request_addr),
      .read_data_out     (read_data_out),
      .read_data_valid   (read_data_valid),
      .done              (done),
      .ready             (ready),
      .wr_count          (wr_count),
      .wrap_flag         (wrap_flag)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, observed=hang required=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_store(input logic [31:0] d);
      m_mem[m_ptr] = d;
      m_ptr = (m_ptr + 1) % DEPTH;
      if (m_count < DEPTH) m_count++;
      if (m_ptr == 0 && m_ring) m_wrap = 1'b1;
   endtask

   task automatic start_record(input bit mode);
      cmd_record = 1'b1;
      cmd_mode   = mode;
      @(negedge sys_clk);
      cmd_record = 1'b0;
      cmd_mode   = 1'b0;
      m_ptr = 0; m_count = 0; m_wrap = 1'b0; m_ring = mode;
      check("rec_ready_low", 128'(ready), 128'(0));
      check("rec_done_clr", 128'(done), 128'(0));
   endtask

   task automatic push(input logic [31:0] d);
      data_in_valid = 1'b1;
      data_in       = d;
      model_store(d);
      @(negedge sys_clk);
      data_in_valid = 1'b0;
      check("wr_count", 128'(wr_count), 128'(m_count));
   endtask

   task automatic stop(input bit with_valid, input logic [31:0] d);
      cmd_stop = 1'b1;
      if (with_valid) begin
         data_in_valid = 1'b1;
         data_in       = d;
         model_store(d);
      end
      @(negedge sys_clk);
      cmd_stop      = 1'b0;
      data_in_valid = 1'b0;
      check("stop_done", 128'(done), 128'(1));
      check("stop_ready", 128'(ready), 128'(1));
      check("stop_wr_count", 128'(wr_count), 128'(m_count));
      check("stop_wrap", 128'(wrap_flag), 128'(m_wrap));
   endtask

   task automatic do_read(input int addr);
      logic [BW-1:0] exp;
      int            base;
      int            n;
      exp  = '0;
      base = m_wrap ? m_ptr : 0;
      for (int k = 0; k < PACK; k++) begin
         exp = {m_mem[(base + addr + k) % DEPTH], exp[BW-1:DW]};
      end
      cmd_read_request  = 1'b1;
      read_request_addr = AW'(addr);
      @(negedge sys_clk);
      cmd_read_request = 1'b0;
      n = 1;
      check("rd_ready_low", 128'(ready), 128'(0));
      while (read_data_valid !== 1'b1 && n < 12) begin
         @(negedge sys_clk);
         n++;
      end
      check("rd_latency", 128'(n), 128'(PACK + 2));
      check("rd_data", 128'(read_data_out), 128'(exp));
      check("rd_ready_back", 128'(ready), 128'(1));
      @(negedge sys_clk);
      check("rd_single_pulse", 128'(read_data_valid), 128'(0));
      check("rd_data_hold", 128'(read_data_out), 128'(exp));
   endtask

   initial begin
      bit saw_rdv;
      int stored;
      int n;
      bit mode;

      // Reset values.
      repeat (3) @(negedge sys_clk);
      check("rst_ready", 128'(ready), 128'(1));
      check("rst_done", 128'(done), 128'(0));
      check("rst_wr_count", 128'(wr_count), 128'(0));
      check("rst_wrap", 128'(wrap_flag), 128'(0));
      check("rst_rdv", 128'(read_data_valid), 128'(0));
      check("rst_rdo", 128'(read_data_out), 128'(0));
      sys_rst_n = 1'b1;
      @(negedge sys_clk);

      // cmd_stop outside RECORD has no effect.
      cmd_stop = 1'b1;
      @(negedge sys_clk);
      cmd_stop = 1'b0;
      check("idle_stop_done", 128'(done), 128'(0));
      check("idle_stop_ready", 128'(ready), 128'(1));

      // One-shot fill of all 16 words; a 17th beat must be discarded.
      start_record(1'b0);
      for (int i = 0; i < DEPTH; i++) push(32'(i));
      check("os_done", 128'(done), 128'(1));
      check("os_ready", 128'(ready), 128'(1));
      check("os_wrap", 128'(wrap_flag), 128'(0));
      data_in_valid = 1'b1;
      data_in       = 32'hDEAD;
      @(negedge sys_clk);
      data_in_valid = 1'b0;
      check("os_extra_count", 128'(wr_count), 128'(DEPTH));
      do_read(0);
      check("os_read0_literal", 128'(read_data_out), 128'({32'd3, 32'd2, 32'd1, 32'd0}));

      // Ring capture of 20 words then stop.
      start_record(1'b1);
      for (int i = 0; i < 20; i++) push(32'(i));
      stop(1'b0, 32'h0);
      do_read(0);
      check("ring_read0_literal", 128'(read_data_out), 128'({32'd7, 32'd6, 32'd5, 32'd4}));
      do_read(14);
      check("ring_read14_literal", 128'(read_data_out), 128'({32'd5, 32'd4, 32'd19, 32'd18}));

      // Stop coinciding with a valid word: the word is kept.
      start_record(1'b1);
      for (int i = 0; i < 3; i++) push($urandom);
      stop(1'b1, 32'hAB);
      check("stop_valid_count", 128'(wr_count), 128'(4));
      do_read(0);

      // Record and read together: record wins; reads during RECORD ignored.
      cmd_record        = 1'b1;
      cmd_mode          = 1'b1;
      cmd_read_request  = 1'b1;
      read_request_addr = '0;
      @(negedge sys_clk);
      cmd_record = 1'b0;
      cmd_mode   = 1'b0;
      m_ptr = 0; m_count = 0; m_wrap = 1'b0; m_ring = 1'b1;
      check("rr_record_wins", 128'(ready), 128'(0));
      saw_rdv = read_data_valid;
      for (int i = 0; i < 8; i++) begin
         cmd_read_request = 1'b1;
         push($urandom);
         saw_rdv = saw_rdv | read_data_valid;
      end
      cmd_read_request = 1'b0;
      stop(1'b0, 32'h0);
      check("rr_no_rdv", 128'(saw_rdv), 128'(0));
      do_read(2);

      // Randomized captures and reads.
      for (int it = 0; it < 6; it++) begin
         mode = 1'($urandom_range(0, 1));
         n    = $urandom_range(1, 40);
         start_record(mode);
         stored = 0;
         while (stored < n && !(mode == 1'b0 && stored == DEPTH)) begin
            if ($urandom_range(0, 3) == 0) begin
               @(negedge sys_clk);
            end else begin
               push($urandom);
               stored++;
            end
         end
         if (mode == 1'b0 && stored == DEPTH) begin
            check("rnd_os_done", 128'(done), 128'(1));
            check("rnd_os_ready", 128'(ready), 128'(1));
         end else begin
            stop(1'b0, 32'h0);
         end
         for (int r = 0; r < 3; r++) do_read($urandom_range(0, DEPTH - 1));
      end

      // Reset in the middle of a read aborts it with no beat.
      cmd_read_request  = 1'b1;
      read_request_addr = 4'd5;
      @(negedge sys_clk);
      cmd_read_request = 1'b0;
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b0;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      check("abort_ready", 128'(ready), 128'(1));
      check("abort_done", 128'(done), 128'(0));
      check("abort_wr_count", 128'(wr_count), 128'(0));
      check("abort_wrap", 128'(wrap_flag), 128'(0));
      check("abort_rdo", 128'(read_data_out), 128'(0));
      saw_rdv = read_data_valid;
      for (int i = 0; i < 8; i++) begin
         @(negedge sys_clk);
         saw_rdv = saw_rdv | read_data_valid;
      end
      check("abort_no_rdv", 128'(saw_rdv), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
